dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the CPU's single-port 512×32 data memory between port 0 (CPU load/store path) and port 1 (debug/program-loader path). It accepts at most one request per cycle and drives registered address, write-data and write-enable to the synchronous RAM. It tracks in-flight reads through a two-stage tag pipeline so that read data returns to the requester that issued it. Sits between the core datapath and the `data_mem` array.

## Interface
- `DATA_WIDTH`, 32, memory word width
- `ADDR_WIDTH`, 9, word-address width (512 words)

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `req0_valid` / `req1_valid`  in  1  request pending on port 0 / 1
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle (combinational from arbitration)
- `req0_we` / `req1_we`  in  1  1 = write, 0 = read
- `req0_addr` / `req1_addr`  in  ADDR_WIDTH  word address
- `req0_wdata` / `req1_wdata`  in  DATA_WIDTH  write data
- `rsp0_valid` / `rsp1_valid`  out  1  read data valid, one-cycle pulse
- `rsp0_rdata` / `rsp1_rdata`  out  DATA_WIDTH  read data
- `mem_we`  out  1  RAM write enable (registered)
- `mem_addr`  out  ADDR_WIDTH  RAM address (registered)
- `mem_wd`  out  DATA_WIDTH  RAM write data (registered)
- `mem_rd`  in  DATA_WIDTH  RAM registered read data (1-cycle latency)

## Operation
- **Handshake:** a transfer occurs when `reqN_valid && reqN_ready`. Requester holds valid/we/addr/wdata stable until ready. At most one of `req0_ready` and `req1_ready` is high in any cycle. A ready is never asserted without the matching valid.
- **Arbitration:**
  - One valid only: that port is granted.
  - Both valid: round-robin. The port not granted last wins.
  - `last_grant` updates only on a transfer.
  - Reset value of `last_grant` = 1, so port 0 wins the first tie.
- **Issue stage (registered):** on a transfer, the next cycle has `mem_addr`=addr, `mem_wd`=wdata, `mem_we`=we. With no transfer, `mem_we`=0 and `mem_addr`/`mem_wd` hold their values.
- **Tag pipeline:** stage 1 `{vld, port}` is registered with the issue stage. `vld` = transfer && !we. Stage 2 is stage 1 delayed one cycle.
- **Response:** when stage 2 is valid, `rspP_valid`=1 and `rspP_rdata`=`mem_rd` for port P. The other port's valid is 0. `rspN_rdata` is 0 when not valid.
- **Writes:** produce no response.
- **Read-during-write, same address, back-to-back:** the RAM returns old data. The arbiter does not forward.
- **Responses:** cannot be back-pressured. Requesters must sink them.
- **Reset:**
  - Tag pipeline cleared.
  - `mem_we`=0, `mem_addr`=0, `mem_wd`=0.
  - Both rsp valids 0, rdata 0.
  - In-flight reads are dropped with no response.
  - Readies are 0 while `reset` is high.

## Timing
- Throughput: one request per cycle, any mix of ports.
- Cycle N: handshake. N+1: RAM command on `mem_*`. N+2: `rspP_valid` with data.
- Read latency, accept to response: 2 cycles, fixed.
- Write commits at the end of cycle N+1. A read of that address accepted at N+1 or later sees the new data.
- Worst-case wait for a continuously valid port under round-robin: 1 cycle.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin tie-break as above.
- Undefined: fixed priority. Port 0 always wins a tie, `last_grant` is not implemented, and port 1 may starve while port 0 stays valid.

## Structure
- Shared package `dmem_pkg`:
  - `DMEM_DATA_WIDTH` (32) and `DMEM_ADDR_WIDTH` (9).
  - `dmem_req_t` packed struct `{we, addr, wdata}`.
  - `dmem_tag_t` packed struct `{vld, port}`.
- Sub-module `dmem_rr_pick`: 2-way grant logic (valids, `last_grant` → grant vector). It swaps to a fixed-priority body under the macro.
- The RAM array stays outside this block.

## Test plan
- Port 0 writes 0x0000_0021 to addr 5 at cycle 10, then reads addr 5 at cycle 11 → `mem_we`=1 at 11; `rsp0_valid` at 13 with 0x21; `rsp1_valid` never asserts.
- Both valid continuously for 6 cycles, reads to addrs 1 (port 0) and 2 (port 1), after reset → grants 0,1,0,1,0,1; responses alternate ports, each 2 cycles after grant. Without the macro: grants 0×6, port 1 ready stays 0.
- Back-to-back reads: port 1 reads addrs 0..7 holding valid → 8 consecutive `rsp1_valid` cycles, data matches preload, no bubbles.
- Same-address hazard: port 1 writes 0xDEAD_BEEF to addr 9 at N, port 0 reads addr 9 at N+1 → `rsp0_rdata`=0xDEAD_BEEF at N+3. A read accepted at N returns the prior value.
- Reset mid-flight: read accepted at N, `reset` high at N+1 → no `rsp*_valid` at N+2, `mem_we`=0, readies 0. First tie after reset is granted to port 0.
- Single valid, never idle-granted: port 1 valid with port 0 idle → `req1_ready`=1 same cycle. `req0_ready` stays 0 throughout.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared widths and request/tag types for the data-memory arbiter.
package dmem_pkg;

   localparam int unsigned DMEM_DATA_WIDTH = 32;
   localparam int unsigned DMEM_ADDR_WIDTH = 9;

   typedef struct packed {
      logic                       we;
      logic [DMEM_ADDR_WIDTH-1:0] addr;
      logic [DMEM_DATA_WIDTH-1:0] wdata;
   } dmem_req_t;

   typedef struct packed {
      logic vld;
      logic port;
   } dmem_tag_t;

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way grant selection. DMEM_ARB_RR_EN selects round-robin tie-break,
// otherwise port 0 has fixed priority.
module dmem_rr_pick (
   input  logic [1:0] valid_i,
`ifdef DMEM_ARB_RR_EN
   input  logic       last_grant_i,
`endif
   output logic [1:0] grant_o
);

   always_comb begin
      grant_o = valid_i;
      if (valid_i == 2'b11) begin
`ifdef DMEM_ARB_RR_EN
         // Favour the port that did not win the previous transfer.
         grant_o = last_grant_i ? 2'b01 : 2'b10;
`else
         grant_o = 2'b01;
`endif
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port synchronous data RAM between two requesters with a
// fixed 2-cycle read latency. DMEM_ARB_RR_EN enables round-robin tie-break.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DMEM_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = DMEM_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic                  req0_we,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [DATA_WIDTH-1:0] req0_wdata,
   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic                  req1_we,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic [DATA_WIDTH-1:0] req1_wdata,
   output logic                  rsp0_valid,
   output logic [DATA_WIDTH-1:0] rsp0_rdata,
   output logic                  rsp1_valid,
   output logic [DATA_WIDTH-1:0] rsp1_rdata,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wd,
   input  logic [DATA_WIDTH-1:0] mem_rd
);

   logic [1:0] grant;
   logic       xfer;
   logic       xfer_port;
   dmem_req_t  req_sel;
   dmem_tag_t  tag1_q;
   dmem_tag_t  tag2_q;

`ifdef DMEM_ARB_RR_EN
   logic last_grant_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant_q <= 1'b1;
      end else if (xfer) begin
         last_grant_q <= xfer_port;
      end
   end
`endif

   dmem_rr_pick u_pick (
      .valid_i      ({req1_valid, req0_valid}),
`ifdef DMEM_ARB_RR_EN
      .last_grant_i (last_grant_q),
`endif
      .grant_o      (grant)
   );

   assign req0_ready = grant[0] & ~reset;
   assign req1_ready = grant[1] & ~reset;
   assign xfer       = req0_ready | req1_ready;
   assign xfer_port  = req1_ready;

   always_comb begin
      if (req1_ready) begin
         req_sel.we    = req1_we;
         req_sel.addr  = req1_addr;
         req_sel.wdata = req1_wdata;
      end else begin
         req_sel.we    = req0_we;
         req_sel.addr  = req0_addr;
         req_sel.wdata = req0_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_we   <= 1'b0;
         mem_addr <= '0;
         mem_wd   <= '0;
         tag1_q   <= '0;
         tag2_q   <= '0;
      end else begin
         mem_we <= xfer & req_sel.we;
         if (xfer) begin
            mem_addr <= req_sel.addr;
            mem_wd   <= req_sel.wdata;
         end
         tag1_q.vld  <= xfer & ~req_sel.we;
         tag1_q.port <= xfer_port;
         tag2_q      <= tag1_q;
      end
   end

   // Stage 2 lines up with the RAM's registered read data.
   always_comb begin
      rsp0_valid = tag2_q.vld & ~tag2_q.port & ~reset;
      rsp1_valid = tag2_q.vld & tag2_q.port & ~reset;
      rsp0_rdata = rsp0_valid ? mem_rd : '0;
      rsp1_rdata = rsp1_valid ? mem_rd : '0;
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter with a transaction-level reference model
// and a behavioural synchronous RAM. Follows DMEM_ARB_RR_EN like the design.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        req0_ready, req1_ready;
   logic        req0_we = 1'b0, req1_we = 1'b0;
   logic [8:0]  req0_addr = '0, req1_addr = '0;
   logic [31:0] req0_wdata = '0, req1_wdata = '0;
   logic        rsp0_valid, rsp1_valid;
   logic [31:0] rsp0_rdata, rsp1_rdata;
   logic        mem_we;
   logic [8:0]  mem_addr;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;

   always #5 clk = ~clk;

   dmem_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_we    (req0_we),
      .req0_addr  (req0_addr),
      .req0_wdata (req0_wdata),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_we    (req1_we),
      .req1_addr  (req1_addr),
      .req1_wdata (req1_wdata),
      .rsp0_valid (rsp0_valid),
      .rsp0_rdata (rsp0_rdata),
      .rsp1_valid (rsp1_valid),
      .rsp1_rdata (rsp1_rdata),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wd     (mem_wd),
      .mem_rd     (mem_rd)
   );

   // Synchronous read-first RAM outside the arbiter.
   logic [31:0] ram [512];
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wd;
      mem_rd <= ram[mem_addr];
   end

   typedef struct {
      int          due;
      bit          port;
      logic [31:0] data;
   } rsp_t;

   logic [31:0] ref_mem [512];
   rsp_t        rsp_q[$];
   int          cyc = 0;
   int          n_tests = 0;
   int          n_fail = 0;
   logic        exp_we = 1'b0;
   logic [8:0]  exp_addr = '0;
   logic [31:0] exp_wd = '0;
   logic        last_port = 1'b1;
   logic [1:0]  obs_rdy;
   logic        pend [2];
   logic        p_we [2];
   logic [8:0]  p_addr [2];
   logic [31:0] p_wd [2];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   // One clock of stimulus, checking and model update.
   task automatic step(input int rate0, input int rate1, input bit rst, input bit rd_mode);
      int          rate [2];
      logic [1:0]  vld;
      logic [1:0]  e_rdy;
      logic        e_v [2];
      logic [31:0] e_d [2];
      rsp_t        r;
      int          xp;
      rate[0] = rate0;
      rate[1] = rate1;
      @(posedge clk);
      #1;
      cyc++;
      reset = rst;
      for (int p = 0; p < 2; p++) begin
         if (!pend[p] && $urandom_range(99) < rate[p]) begin
            pend[p] = 1'b1;
            if (rd_mode) begin
               p_we[p]   = 1'b0;
               p_addr[p] = (p == 0) ? 9'd1 : 9'd2;
            end else begin
               p_we[p]   = ($urandom_range(2) == 0);
               p_addr[p] = 9'($urandom_range(15));
            end
            p_wd[p] = $urandom;
         end
      end
      req0_valid = pend[0]; req0_we = p_we[0]; req0_addr = p_addr[0]; req0_wdata = p_wd[0];
      req1_valid = pend[1]; req1_we = p_we[1]; req1_addr = p_addr[1]; req1_wdata = p_wd[1];
      @(negedge clk);

      vld = {pend[1], pend[0]};
      if (rst) e_rdy = 2'b00;
      else begin
         case (vld)
            2'b01:   e_rdy = 2'b01;
            2'b10:   e_rdy = 2'b10;
`ifdef DMEM_ARB_RR_EN
            2'b11:   e_rdy = last_port ? 2'b01 : 2'b10;
`else
            2'b11:   e_rdy = 2'b01;
`endif
            default: e_rdy = 2'b00;
         endcase
      end
      obs_rdy = {req1_ready, req0_ready};
      check_eq("ready", 64'(obs_rdy), 64'(e_rdy));
      check_eq("mem_we", 64'(mem_we), 64'(exp_we));
      check_eq("mem_addr", 64'(mem_addr), 64'(exp_addr));
      check_eq("mem_wd", 64'(mem_wd), 64'(exp_wd));

      if (rst) rsp_q.delete();
      e_v[0] = 1'b0; e_v[1] = 1'b0; e_d[0] = '0; e_d[1] = '0;
      if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
         r = rsp_q.pop_front();
         e_v[r.port] = 1'b1;
         e_d[r.port] = r.data;
      end
      check_eq("rsp0_valid", 64'(rsp0_valid), 64'(e_v[0]));
      check_eq("rsp0_rdata", 64'(rsp0_rdata), 64'(e_d[0]));
      check_eq("rsp1_valid", 64'(rsp1_valid), 64'(e_v[1]));
      check_eq("rsp1_rdata", 64'(rsp1_rdata), 64'(e_d[1]));

      if (rst) begin
         exp_we = 1'b0; exp_addr = '0; exp_wd = '0; last_port = 1'b1;
      end else if (e_rdy != 2'b00) begin
         xp = e_rdy[1] ? 1 : 0;
         exp_we   = p_we[xp];
         exp_addr = p_addr[xp];
         exp_wd   = p_wd[xp];
         if (p_we[xp]) ref_mem[p_addr[xp]] = p_wd[xp];
         else begin
            r.due  = cyc + 2;
            r.port = (xp == 1);
            r.data = ref_mem[p_addr[xp]];
            rsp_q.push_back(r);
         end
         last_port = (xp == 1);
         pend[xp]  = 1'b0;
      end else begin
         exp_we = 1'b0;
      end
   endtask

   initial begin
      logic [31:0] v;
      logic [1:0]  tie_exp;
      for (int i = 0; i < 512; i++) begin
         v = $urandom;
         ram[i]     = v;
         ref_mem[i] = v;
      end
      pend[0] = 1'b0; pend[1] = 1'b0;
      p_we[0] = 1'b0; p_we[1] = 1'b0;
      p_addr[0] = '0; p_addr[1] = '0;
      p_wd[0] = '0; p_wd[1] = '0;

      // Valids held high during reset must not be accepted.
      for (int i = 0; i < 3; i++) step(100, 100, 1'b1, 1'b1);

      // Continuous tie after reset: fixed grant pattern.
      for (int i = 0; i < 6; i++) begin
         step(100, 100, 1'b0, 1'b1);
`ifdef DMEM_ARB_RR_EN
         tie_exp = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
         tie_exp = 2'b01;
`endif
         check_eq("tie_grant", 64'(obs_rdy), 64'(tie_exp));
      end

      // Mixed random traffic with a reset landing mid-flight.
      for (int i = 0; i < 400; i++) step(60, 60, (i == 150), 1'b0);
      for (int i = 0; i < 300; i++) step(30, 90, 1'b0, 1'b0);
      for (int i = 0; i < 200; i++) step(90, 90, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) step(0, 0, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
